dmem_lsu_ctrl: RTL and testbench

- Load/store sequencer between the RV32I execute stage and the single-port, word-wide, clocked data memory (1-cycle registered read, no byte enables).
- Executes LB/LH/LW/LBU/LHU/SB/SH/SW:
  - byte-lane extraction and sign/zero extension on loads;
  - read-modify-write for SB/SH;
  - alignment checking.
- One request in flight; simple valid/ready request, single-cycle response pulse.

---
 rtl/dmem_ctrl_pkg.sv | 38 +++
 rtl/dmem_lane_align.sv | 57 +++++
 rtl/dmem_lsu_ctrl.sv | 154 +++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the RV32I load/store sequencer: funct3 encodings,
// FSM state encoding and the accept-time legality/alignment check.
package dmem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CAPT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4,
    S_ERR   = 3'd5
  } lsu_state_e;

  // True when the op is a defined RV32I access and naturally aligned.
  // Unsigned variants exist only for loads.
  function automatic logic is_legal_aligned(input logic       we,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a 32-bit memory word and the core:
// load path extracts and extends a lane, store path merges a lane into the
// word read back from memory (read-modify-write for SB/SH).
module dmem_lane_align
  import dmem_ctrl_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [2:0]          funct3,
  input  logic [1:0]          addr_lo,
  input  logic [DATA_LEN-1:0] r_word,
  input  logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] load_data,
  output logic [DATA_LEN-1:0] merged_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword lanes out of the read word.
  always_comb begin
    byte_s = r_word[{addr_lo, 3'b000} +: 8];
    if (addr_lo[1]) begin
      half_s = r_word[31:16];
    end else begin
      half_s = r_word[15:0];
    end
  end

  // Sign- or zero-extend the selected lane according to the load type.
  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_BU:   load_data = {24'h000000, byte_s};
      F3_HU:   load_data = {16'h0000, half_s};
      default: load_data = r_word;
    endcase
  end

  // Overlay the store data onto the addressed lane of the read word.
  always_comb begin
    merged_word = r_word;
    case (funct3)
      F3_B: merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) begin
          merged_word[31:16] = wdata[15:0];
        end else begin
          merged_word[15:0] = wdata[15:0];
        end
      end
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the RV32I execute stage and a single-port,
// word-wide data memory with a registered read. One request in flight;
// sub-word stores are done as read-modify-write.
module dmem_lsu_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int DATA_LEN   = 32
) (
  input  logic                  d_clk,
  input  logic                  d_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_LEN-1:0]   req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_LEN-1:0]   rsp_rdata,
  output logic                  rsp_misalign,
  output logic                  mem_cs,
  output logic                  mem_rw_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_LEN-1:0]   mem_w_data,
  input  logic [DATA_LEN-1:0]   mem_r_data
);

  lsu_state_e            state_q, state_d;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_lo_q;
  logic [MEM_ADDR_W-1:0] waddr_q;
  logic [DATA_LEN-1:0]   wdata_q;
  logic [DATA_LEN-1:0]   rdata_q;
  logic [DATA_LEN-1:0]   load_data_s;
  logic [DATA_LEN-1:0]   merged_s;
  logic                  accept_s;
  logic                  unused_addr_s;

  // Address bits above the memory window alias; they are deliberately dropped.
  assign unused_addr_s = ^req_addr[ADDR_W-1:MEM_ADDR_W+2];
  assign accept_s      = req_valid & (state_q == S_IDLE);
  assign mem_addr      = waddr_q;

  dmem_lane_align #(.DATA_LEN(DATA_LEN)) u_lane_align (
    .funct3      (funct3_q),
    .addr_lo     (addr_lo_q),
    .r_word      (mem_r_data),
    .wdata       (wdata_q),
    .load_data   (load_data_s),
    .merged_word (merged_s)
  );

  // FSM state register; reset aborts any op before its write cycle.
  always_ff @(posedge d_clk or posedge d_rst) begin
    if (d_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the request fields on the accepting edge.
  always_ff @(posedge d_clk or posedge d_rst) begin
    if (d_rst) begin
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      waddr_q   <= {MEM_ADDR_W{1'b0}};
      wdata_q   <= {DATA_LEN{1'b0}};
    end else if (accept_s) begin
      we_q      <= req_we;
      funct3_q  <= req_funct3;
      addr_lo_q <= req_addr[1:0];
      waddr_q   <= req_addr[MEM_ADDR_W+1:2];
      wdata_q   <= req_wdata;
    end
  end

  // In CAPT register either the extended load value or the merged store word.
  always_ff @(posedge d_clk or posedge d_rst) begin
    if (d_rst) begin
      rdata_q <= {DATA_LEN{1'b0}};
    end else if (state_q == S_CAPT) begin
      rdata_q <= we_q ? merged_s : load_data_s;
    end
  end

  // Next-state: bad ops go straight to ERR, SW skips the read phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!is_legal_aligned(req_we, req_funct3, req_addr[1:0])) begin
            state_d = S_ERR;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ:  state_d = S_CAPT;
      S_CAPT:  state_d = we_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_rdata    = {DATA_LEN{1'b0}};
    rsp_misalign = 1'b0;
    mem_cs       = 1'b0;
    mem_rw_en    = 1'b0;
    mem_w_data   = {DATA_LEN{1'b0}};
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_READ: mem_cs = 1'b1;
      S_CAPT: mem_cs = 1'b0;
      S_WRITE: begin
        mem_cs    = 1'b1;
        mem_rw_en = 1'b1;
        if (funct3_q == F3_W) begin
          mem_w_data = wdata_q;
        end else begin
          mem_w_data = rdata_q;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (we_q) begin
          rsp_rdata = {DATA_LEN{1'b0}};
        end else begin
          rsp_rdata = rdata_q;
        end
      end
      S_ERR: begin
        rsp_valid    = 1'b1;
        rsp_misalign = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Scoreboard bench for dmem_lsu_ctrl: a driver issues requests and pushes
// expectations from a word-array reference model; a monitor pops and checks
// each response (data, error flag, latency, memory activity).
module tb_dmem_lsu_ctrl;

  localparam int NW = 1024;

  logic        d_clk = 1'b0;
  logic        d_rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_misalign;
  logic [31:0] rsp_rdata;
  logic        mem_cs, mem_rw_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_w_data, mem_r_data;

  always #5 d_clk = ~d_clk;

  dmem_lsu_ctrl #(.ADDR_W(32), .MEM_ADDR_W(10), .DATA_LEN(32)) dut (
    .d_clk(d_clk), .d_rst(d_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign),
    .mem_cs(mem_cs), .mem_rw_en(mem_rw_en), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  // External memory: registered read, garbage on the read port otherwise.
  logic [31:0] mem [0:NW-1];
  always @(posedge d_clk or posedge d_rst) begin
    if (d_rst) begin
      for (int i = 0; i < NW; i++) mem[i] <= 32'h0;
      mem_r_data <= 32'h0;
    end else begin
      if (mem_cs && !mem_rw_en) mem_r_data <= mem[mem_addr];
      else mem_r_data <= $urandom;
      if (mem_cs && mem_rw_en) mem[mem_addr] <= mem_w_data;
    end
  end

  int cyc = 0;
  always @(posedge d_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          acc;
    int          lat;
    int          ncs;
    int          nwr;
    logic [9:0]  widx;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [0:NW-1];

  // Reference: memory as a word array, byte address taken modulo 4 KiB.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input int acc);
    exp_t        e;
    logic [9:0]  idx;
    logic [31:0] w, v, mask, nw;
    int          sh;
    logic        bad;
    idx = addr[11:2];
    sh  = int'(addr[1:0]) * 8;
    bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (!bad && f3[1:0] == 2'd1 && addr[0]) bad = 1'b1;
    if (!bad && f3[1:0] == 2'd2 && addr[1:0] != 2'd0) bad = 1'b1;
    e.acc = acc; e.widx = idx; e.rdata = 32'h0; e.mis = 1'b0;
    w = ref_mem[idx];
    if (bad) begin
      e.mis = 1'b1; e.lat = 1; e.ncs = 0; e.nwr = 0;
    end else if (!we) begin
      v = w >> sh;
      case (f3)
        3'd0: e.rdata = {{24{v[7]}}, v[7:0]};
        3'd1: e.rdata = {{16{v[15]}}, v[15:0]};
        3'd4: e.rdata = {24'h0, v[7:0]};
        3'd5: e.rdata = {16'h0, v[15:0]};
        default: e.rdata = w;
      endcase
      e.lat = 3; e.ncs = 1; e.nwr = 0;
    end else begin
      if (f3 == 3'd2) begin
        nw = wd; e.lat = 2; e.ncs = 1;
      end else begin
        mask = (f3 == 3'd0) ? (32'hFF << sh) : (32'hFFFF << sh);
        nw = (w & ~mask) | ((wd << sh) & mask);
        e.lat = 4; e.ncs = 2;
      end
      e.nwr = 1;
      ref_mem[idx] = nw;
    end
    return e;
  endfunction

  // Monitor: track memory activity per op, check each response against the queue.
  int   ncs = 0, nwr = 0, wr_total = 0;
  logic bad_wd = 1'b0, bad_ad = 1'b0;
  exp_t e;
  always @(negedge d_clk) begin
    if (d_rst) begin
      q.delete(); ncs = 0; nwr = 0; bad_wd = 1'b0; bad_ad = 1'b0;
    end else begin
      if (mem_cs) begin
        ncs++;
        if (q.size() > 0 && mem_addr != q[0].widx) bad_ad = 1'b1;
      end
      if (mem_cs && mem_rw_en) begin nwr++; wr_total++; end
      if (!(mem_cs && mem_rw_en) && mem_w_data != 32'h0) bad_wd = 1'b1;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got response with empty scoreboard");
        end else begin
          e = q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_misalign", {31'h0, rsp_misalign}, {31'h0, e.mis});
          chk("latency", cyc - e.acc + 1, e.lat);
          chk("mem_cs_cycles", ncs, e.ncs);
          chk("mem_write_cycles", nwr, e.nwr);
          chk("mem_addr_during_access", {31'h0, bad_ad}, 32'h0);
          chk("w_data_zero_outside_write", {31'h0, bad_wd}, 32'h0);
        end
        ncs = 0; nwr = 0; bad_wd = 1'b0; bad_ad = 1'b0;
      end
    end
  end

  // Present a request (valid stays high) until accepted; queue its expectation.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int acc);
    int n;
    @(negedge d_clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge d_clk); n++; end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready 0 after %0d cycles, required 1", n);
      req_valid = 1'b0; acc = -1;
    end else begin
      @(posedge d_clk); #1;
      acc = cyc;
      q.push_back(model(we, f3, addr, wd, acc));
    end
  endtask

  task automatic idle();
    @(negedge d_clk); req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin @(negedge d_clk); n++; end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge d_clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_rsp"}, {30'h0, rsp_valid, rsp_misalign}, 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_mem_ctl"}, {30'h0, mem_cs, mem_rw_en}, 32'h0);
    chk({tag, "_mem_addr"}, {22'h0, mem_addr}, 32'h0);
    chk({tag, "_mem_w_data"}, mem_w_data, 32'h0);
  endtask

  initial begin
    int a1, a2, snap;
    logic we;
    logic [2:0] f3;
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
    d_rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge d_clk);
    #1 chk_quiet("reset");
    @(negedge d_clk); d_rst = 1'b0;

    // Word store/load, then every sub-word load flavour on the same word.
    do_req(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, a1);
    do_req(1'b0, 3'd2, 32'h8, 32'h0, a1);
    do_req(1'b0, 3'd0, 32'h9, 32'h0, a1);
    do_req(1'b0, 3'd4, 32'h9, 32'h0, a1);
    do_req(1'b0, 3'd1, 32'hA, 32'h0, a1);
    do_req(1'b0, 3'd5, 32'hA, 32'h0, a1);
    // Read-modify-write stores.
    do_req(1'b1, 3'd0, 32'hB, 32'h00000012, a1);
    do_req(1'b1, 3'd1, 32'h8, 32'hCAFE1234, a1);
    // Rejected requests.
    do_req(1'b0, 3'd2, 32'h6, 32'h0, a1);
    do_req(1'b1, 3'd1, 32'h3, 32'hFFFFFFFF, a1);
    do_req(1'b0, 3'd3, 32'h8, 32'h0, a1);
    idle();
    drain();
    chk("word2_after_rmw", mem[2], 32'h12AD1234);

    // Back-to-back with valid held high; 0x1008 aliases 0x8.
    do_req(1'b0, 3'd2, 32'h1008, 32'h0, a1);
    do_req(1'b0, 3'd2, 32'h8, 32'h0, a2);
    idle();
    chk("b2b_accept_spacing", a2 - a1, 4);
    drain();

    // Reset during CAPT of an SB: no write must happen.
    snap = wr_total;
    do_req(1'b1, 3'd0, 32'h8, 32'h000000A5, a1);
    req_valid = 1'b0;
    @(posedge d_clk); #1;
    d_rst = 1'b1;
    #1 chk_quiet("midop_reset");
    @(negedge d_clk); @(negedge d_clk);
    d_rst = 1'b0;
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
    chk("no_write_after_reset", wr_total, snap);
    do_req(1'b0, 3'd2, 32'h8, 32'h0, a1);
    idle();
    drain();

    // Randomized traffic in a small aliased window, with random idle gaps.
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      do_req(we, f3, $urandom & 32'hFFFF_F03F, $urandom, a1);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(negedge d_clk);
      end
    end
    idle();
    drain();
    for (int i = 0; i < 16; i++) chk("final_mem_word", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
